uart_tx: RTL and testbench

Generic UART transmitter with an input FIFO. It accepts words over a valid/ready handshake, buffers them, and serialises each one onto a single line. Every frame is a start bit, WIDTH data bits sent LSB first, an optional even-parity bit and one stop bit. Each bit is held for SAMPLES clocks, so the output drives the serial input of the matching UART receiver directly, using the same SAMPLES and PARITY values.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 64 ++++++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and parameter-free frame helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // Words wider than 64 bits would need a wider argument here.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

    function automatic int frame_len(input int width, input int parity, input int samples);
        return samples * (width + parity + 2);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with the head word visible on dout without latency.
// Latency: a push is visible on empty/fill/dout after the next edge.
// Backpressure: pushes are ignored while full and pops are ignored while empty.
module uart_fifo #(
    parameter int WIDTH       = 8,
    parameter int BUF_ADDR_SZ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [BUF_ADDR_SZ:0]   fill
);
    localparam int DEPTH = 1 << BUF_ADDR_SZ;
    localparam logic [BUF_ADDR_SZ-1:0] PTR_ONE   = BUF_ADDR_SZ'(1);
    localparam logic [BUF_ADDR_SZ:0]   CNT_ONE   = (BUF_ADDR_SZ+1)'(1);
    localparam logic [BUF_ADDR_SZ:0]   CNT_DEPTH = (BUF_ADDR_SZ+1)'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [BUF_ADDR_SZ-1:0] wr_ptr;
    logic [BUF_ADDR_SZ-1:0] rd_ptr;
    logic [BUF_ADDR_SZ:0]   count;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_DEPTH);
    assign empty = (count == '0);
    assign fill  = count;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, start + WIDTH data (LSB first) + optional even parity + stop.
// Latency: TxOut falls one clock after a push into an empty FIFO with the FSM idle.
// Backpressure: wr_ready drops while the FIFO is full; frames run back-to-back while words remain.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PARITY      = 0,
    parameter int SAMPLES     = 16,
    parameter int BUF_ADDR_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic                 TxOut,
    output logic                 busy,
    output logic [BUF_ADDR_SZ:0] fill
);
    localparam int TW = $clog2(SAMPLES);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    tx_state_t        state, state_nxt;
    logic [TW-1:0]    tick_cnt, tick_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [WIDTH-1:0] shift, shift_nxt;
    logic             par_bit, par_nxt;
    logic             tx_q, tx_nxt;
    logic             tick_done;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    assign push = wr_valid && !fifo_full;

    uart_fifo #(
        .WIDTH       (WIDTH),
        .BUF_ADDR_SZ (BUF_ADDR_SZ)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            par_bit  <= par_nxt;
            tx_q     <= tx_nxt;
        end
    end

    assign tick_done = (tick_cnt == TICK_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = START;
            START: if (tick_done) state_nxt = DATA;
            DATA:  if (tick_done && bit_cnt == BIT_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (tick_done) state_nxt = STOP;
            STOP:  if (tick_done) state_nxt = fifo_empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // TxOut is loaded with the level of the state being entered, so it stays a pure register.
    always_comb begin
        pop       = !fifo_empty && ((state == IDLE) || (state == STOP && tick_done));
        tick_nxt  = tick_cnt + TICK_ONE;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        par_nxt   = par_bit;
        if (pop) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            shift_nxt = fifo_dout;
            par_nxt   = even_parity(64'(fifo_dout));
        end else if (state == IDLE) begin
            tick_nxt = '0;
        end else if (state == DATA && tick_done) begin
            shift_nxt = shift >> 1;
            bit_nxt   = bit_cnt + BIT_ONE;
        end
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PAR:     tx_nxt = par_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

    assign TxOut    = tx_q;
    assign wr_ready = !fifo_full;
    assign busy     = (state != IDLE) || (fill != '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with and without parity, SAMPLES = 16, depth 16.
module tb_uart_tx;
    localparam int SMP = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       r0, r1, t0, t1, b0, b1;
    logic [4:0] f0, f1;
    int         total = 0;
    int         bad   = 0;
    logic       seen_low, seen_busy;

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(8), .PARITY(0), .SAMPLES(SMP), .BUF_ADDR_SZ(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_data(d0), .wr_valid(v0), .wr_ready(r0),
        .TxOut(t0), .busy(b0), .fill(f0)
    );

    uart_tx #(.WIDTH(8), .PARITY(1), .SAMPLES(SMP), .BUF_ADDR_SZ(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_data(d1), .wr_valid(v1), .wr_ready(r1),
        .TxOut(t1), .busy(b1), .fill(f1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame line levels, bit 0 first: start, 8 data bits LSB first, stop.
    function automatic logic [15:0] fr(input logic [7:0] w);
        return {7'b0, 1'b1, w, 1'b0};
    endfunction

    // Called at a negedge 'elapsed0' clocks after the frame's start edge; samples each
    // remaining bit mid-period and returns 16*nbits - stop_short clocks after that edge.
    task automatic check_frame(input logic sel, input logic [15:0] exp_bits, input int nbits,
                               input int elapsed0, input int stop_short);
        int el;
        el = elapsed0;
        for (int k = 0; k < nbits; k++) begin
            if (SMP * k + SMP / 2 >= el) begin
                repeat (SMP * k + SMP / 2 - el) @(negedge clk);
                el = SMP * k + SMP / 2;
                chk($sformatf("dut%0d_bit%0d", sel, k), 32'(sel ? t1 : t0), 32'(exp_bits[k]));
            end
        end
        repeat (SMP * nbits - stop_short - el) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx0", 32'(t0), 32'd1);
        chk("rst_tx1", 32'(t1), 32'd1);
        chk("rst_ready", 32'(r0), 32'd1);
        chk("rst_busy", 32'(b0), 32'd0);
        chk("rst_fill", 32'(f0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xA5, no parity: exact falling edge and frame end.
        d0 = 8'hA5; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        chk("a5_pre_fall", 32'(t0), 32'd1);
        chk("a5_busy", 32'(b0), 32'd1);
        chk("a5_fill1", 32'(f0), 32'd1);
        @(negedge clk);
        chk("a5_fall", 32'(t0), 32'd0);
        chk("a5_fill0", 32'(f0), 32'd0);
        repeat (15) @(negedge clk);
        chk("a5_start_last", 32'(t0), 32'd0);
        @(negedge clk);
        chk("a5_d0_first", 32'(t0), 32'd1);
        check_frame(1'b0, 16'h034A, 10, 16, 1);
        chk("a5_busy_stop", 32'(b0), 32'd1);
        @(negedge clk);
        chk("a5_idle_busy", 32'(b0), 32'd0);
        chk("a5_idle_tx", 32'(t0), 32'd1);

        // Parity: 0x07 -> parity 1, 0xA5 -> parity 0, back-to-back 176-clock frames.
        d1 = 8'h07; v1 = 1'b1;
        @(negedge clk);
        d1 = 8'hA5;
        @(negedge clk);
        v1 = 1'b0;
        chk("par_fall", 32'(t1), 32'd0);
        check_frame(1'b1, 16'h060E, 11, 0, 0);
        check_frame(1'b1, 16'h054A, 11, 0, 0);
        chk("par_idle_busy", 32'(b1), 32'd0);

        // Fill to full: 0x00..0x10 on consecutive edges, 0x11 held until space frees.
        v0 = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            d0 = 8'(i);
            @(negedge clk);
            chk($sformatf("fill_%0d", i), 32'(f0), (i == 0) ? 32'd1 : 32'(i));
            chk($sformatf("ready_%0d", i), 32'(r0), (i < 16) ? 32'd1 : 32'd0);
        end
        d0 = 8'h11;
        chk("full_start_bit", 32'(t0), 32'd0);
        check_frame(1'b0, fr(8'h00), 10, 15, 0);
        chk("full_ready_rise", 32'(r0), 32'd1);
        chk("full_fill15", 32'(f0), 32'd15);
        chk("full_next_start", 32'(t0), 32'd0);
        @(negedge clk);
        v0 = 1'b0;
        chk("full_refill", 32'(f0), 32'd16);
        chk("full_ready_low", 32'(r0), 32'd0);
        check_frame(1'b0, fr(8'h01), 10, 1, 0);
        for (int w = 2; w <= 17; w++) begin
            check_frame(1'b0, fr(8'(w)), 10, 0, 0);
        end
        chk("full_done_busy", 32'(b0), 32'd0);
        chk("full_done_tx", 32'(t0), 32'd1);

        // Reset during data bit 3 of 0x3C with two words queued.
        d0 = 8'h3C; v0 = 1'b1;
        @(negedge clk);
        d0 = 8'h11;
        @(negedge clk);
        d0 = 8'h22;
        @(negedge clk);
        v0 = 1'b0;
        chk("mr_fill2", 32'(f0), 32'd2);
        repeat (39) @(negedge clk);
        chk("mr_d1", 32'(t0), 32'd0);
        repeat (32) @(negedge clk);
        chk("mr_d3", 32'(t0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_tx", 32'(t0), 32'd1);
        chk("mr_fill", 32'(f0), 32'd0);
        chk("mr_ready", 32'(r0), 32'd1);
        chk("mr_busy", 32'(b0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_low = 1'b0; seen_busy = 1'b0;
        repeat (2 * uart_pkg::frame_len(8, 0, SMP)) begin
            @(negedge clk);
            if (!t0) seen_low = 1'b1;
            if (b0) seen_busy = 1'b1;
        end
        chk("mr_no_frame", 32'(seen_low), 32'd0);
        chk("mr_no_busy", 32'(seen_busy), 32'd0);

        // Push on the exact STOP->START pop edge with fill = 2.
        d0 = 8'h5A; v0 = 1'b1;
        @(negedge clk);
        d0 = 8'hC3;
        @(negedge clk);
        d0 = 8'h81;
        @(negedge clk);
        v0 = 1'b0;
        chk("col_fill2", 32'(f0), 32'd2);
        check_frame(1'b0, fr(8'h5A), 10, 1, 1);
        chk("col_pre", 32'(f0), 32'd2);
        d0 = 8'h3E; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        chk("col_fill_same", 32'(f0), 32'd2);
        chk("col_start", 32'(t0), 32'd0);
        check_frame(1'b0, fr(8'hC3), 10, 0, 0);
        check_frame(1'b0, fr(8'h81), 10, 0, 0);
        check_frame(1'b0, fr(8'h3E), 10, 0, 0);
        chk("col_done_busy", 32'(b0), 32'd0);
        chk("col_done_fill", 32'(f0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
